// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS datapath: ALU control codes,
// ALUOp and funct values, and bit positions inside the decoded control word.
package mips_pkg;

  typedef enum logic [2:0] {
    GIN_AND = 3'b000,
    GIN_OR  = 3'b001,
    GIN_ADD = 3'b010,
    GIN_SRA = 3'b011,
    GIN_SUB = 3'b110,
    GIN_SLT = 3'b111
  } gin_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;

  // id_ctl = {regdst, alusrc, memread, memwrite, memtoreg, regwrite}
  localparam int CTL_REGDST   = 5;
  localparam int CTL_ALUSRC   = 4;
  localparam int CTL_MEMREAD  = 3;
  localparam int CTL_MEMWRITE = 2;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_REGWRITE = 0;

  // ex_ctl keeps the low four bits of id_ctl, so memread sits at bit 3 there too
  localparam int EXCTL_MEMREAD = 3;

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decoder: maps ALUOp and the R-type funct field onto the ALU's
// 3-bit control line. Shared with the single-cycle datapath.
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] gin_o,
  output logic       illegal_o
);

  always_comb begin
    gin_o     = GIN_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: gin_o = GIN_ADD;
      ALUOP_SUB: gin_o = GIN_SUB;
      ALUOP_OR:  gin_o = GIN_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD: gin_o = GIN_ADD;
          FUNCT_SUB: gin_o = GIN_SUB;
          FUNCT_AND: gin_o = GIN_AND;
          FUNCT_OR:  gin_o = GIN_OR;
          FUNCT_SLT: gin_o = GIN_SLT;
          FUNCT_SRA: gin_o = GIN_SRA;
          default: begin
            // unknown funct still drives a harmless add
            gin_o     = GIN_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded operands, registers
// the ALU control, forwards from EX/MEM and MEM/WB, and stalls on load-use.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs_num,
  input  logic [REGBITS-1:0] id_rt_num,
  input  logic [REGBITS-1:0] id_rd_num,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [1:0]         id_aluop,
  input  logic [5:0]         id_funct,
  input  logic [5:0]         id_ctl,
  input  logic               flush,
  input  logic               exmem_regwrite,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_regwrite,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_result,
  output logic               stall,
  output logic               ex_valid,
  output logic [2:0]         gin,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [WIDTH-1:0]   store_data,
  output logic [REGBITS-1:0] ex_dest,
  output logic [3:0]         ex_ctl,
  output logic               illegal,
  output logic [CNTW-1:0]    stall_count
);

  logic               ex_valid_q;
  logic [REGBITS-1:0] rs_num_q, rt_num_q, dest_q;
  logic [WIDTH-1:0]   rs_data_q, rt_data_q, imm_q;
  logic               alusrc_q;
  logic [3:0]         ctl_q;
  logic [2:0]         gin_q;
  logic               illegal_q;
  logic [CNTW-1:0]    stall_count_q, stall_count_d;

  logic [2:0]         dec_gin;
  logic               dec_illegal;
  logic               hazard;
  logic [WIDTH-1:0]   fwd_a, fwd_b;

  alu_ctrl u_alu_ctrl (
    .aluop_i   (id_aluop),
    .funct_i   (id_funct),
    .gin_o     (dec_gin),
    .illegal_o (dec_illegal)
  );

  // load in EX whose destination is read by the instruction sitting in ID
  assign hazard = ex_valid_q && ctl_q[EXCTL_MEMREAD] && (dest_q != '0) && id_valid &&
                  ((dest_q == id_rs_num) || (dest_q == id_rt_num));
  assign stall  = hazard && !flush;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      rs_num_q      <= '0;
      rt_num_q      <= '0;
      dest_q        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      alusrc_q      <= 1'b0;
      ctl_q         <= '0;
      gin_q         <= GIN_ADD;
      illegal_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      if (flush || hazard) begin
        // bubble: operand registers keep stale values, nothing downstream acts on them
        ex_valid_q <= 1'b0;
        ctl_q      <= '0;
        illegal_q  <= 1'b0;
      end else begin
        ex_valid_q <= id_valid;
        rs_num_q   <= id_rs_num;
        rt_num_q   <= id_rt_num;
        dest_q     <= id_ctl[CTL_REGDST] ? id_rd_num : id_rt_num;
        rs_data_q  <= id_rs_data;
        rt_data_q  <= id_rt_data;
        imm_q      <= id_imm;
        alusrc_q   <= id_ctl[CTL_ALUSRC];
        ctl_q      <= id_valid ? id_ctl[CTL_MEMREAD:CTL_REGWRITE] : 4'b0000;
        gin_q      <= dec_gin;
        illegal_q  <= dec_illegal && id_valid;
      end
    end
  end

  // EX/MEM wins over MEM/WB; register 0 is hardwired and never forwarded
  function automatic logic [WIDTH-1:0] forward(input logic [REGBITS-1:0] num,
                                               input logic [WIDTH-1:0]   latched);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == num)) return exmem_result;
    if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == num)) return memwb_result;
    return latched;
  endfunction

  always_comb begin
    fwd_a = forward(rs_num_q, rs_data_q);
    fwd_b = forward(rt_num_q, rt_data_q);
  end

  assign ex_valid    = ex_valid_q;
  assign gin         = gin_q;
  assign alu_a       = fwd_a;
  assign alu_b       = alusrc_q ? imm_q : fwd_b;
  assign store_data  = fwd_b;
  assign ex_dest     = dest_q;
  assign ex_ctl      = ctl_q;
  assign illegal     = illegal_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a directed vector table covering reset, decode,
// forwarding, load-use stall, flush and reset-during-stall, then random traffic.
module tb_id_ex_stage;

  localparam int W = 32;
  localparam int R = 5;
  localparam int C = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, id_valid, flush, exmem_regwrite, memwb_regwrite;
  logic [R-1:0] id_rs_num, id_rt_num, id_rd_num, exmem_rd, memwb_rd;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic [1:0]   id_aluop;
  logic [5:0]   id_funct, id_ctl;
  logic         stall, ex_valid, illegal;
  logic [2:0]   gin;
  logic [W-1:0] alu_a, alu_b, store_data;
  logic [R-1:0] ex_dest;
  logic [3:0]   ex_ctl;
  logic [C-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  id_ex_stage #(.WIDTH(W), .REGBITS(R), .CNTW(C)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_rd_num(id_rd_num),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_ctl(id_ctl), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .gin(gin), .alu_a(alu_a), .alu_b(alu_b),
    .store_data(store_data), .ex_dest(ex_dest), .ex_ctl(ex_ctl), .illegal(illegal),
    .stall_count(stall_count)
  );

  typedef struct {
    logic       rst, idv;
    logic [4:0] rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [1:0] aluop;
    logic [5:0] funct, ctl;
    logic       flush, xw;
    logic [4:0] xrd;
    logic [31:0] xres;
    logic       ww;
    logic [4:0] wrd;
    logic [31:0] wres;
  } vin_t;

  // chk: 0 = nothing, 1 = control/counter only, 2 = control plus operands
  typedef struct {
    int          chk;
    logic        stall, exv;
    logic [2:0]  gin;
    logic [31:0] a, b, sd;
    logic [4:0]  dest;
    logic [3:0]  ctl;
    logic        ill;
    logic [15:0] cnt;
  } vexp_t;

  typedef struct { vin_t i; vexp_t e; } vec_t;

  vec_t tbl[$];

  function automatic vin_t I(logic rst, logic idv, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                             logic [1:0] aluop, logic [5:0] funct, logic [5:0] ctl);
    vin_t v;
    v.rst = rst; v.idv = idv; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rsd = rsd; v.rtd = rtd; v.imm = imm; v.aluop = aluop; v.funct = funct; v.ctl = ctl;
    v.flush = 0; v.xw = 0; v.xrd = 0; v.xres = 0; v.ww = 0; v.wrd = 0; v.wres = 0;
    return v;
  endfunction

  function automatic vexp_t E(int chk, logic st, logic exv, logic [2:0] g, logic [31:0] a,
                              logic [31:0] b, logic [31:0] sd, logic [4:0] dest,
                              logic [3:0] ctl, logic ill, logic [15:0] cnt);
    vexp_t e;
    e.chk = chk; e.stall = st; e.exv = exv; e.gin = g; e.a = a; e.b = b; e.sd = sd;
    e.dest = dest; e.ctl = ctl; e.ill = ill; e.cnt = cnt;
    return e;
  endfunction

  task automatic add(input vin_t i, input vexp_t e);
    vec_t r;
    r.i = i; r.e = e;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vin_t v);
    reset = v.rst; id_valid = v.idv; id_rs_num = v.rs; id_rt_num = v.rt; id_rd_num = v.rd;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.imm; id_aluop = v.aluop;
    id_funct = v.funct; id_ctl = v.ctl; flush = v.flush;
    exmem_regwrite = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_regwrite = v.ww; memwb_rd = v.wrd; memwb_result = v.wres;
  endtask

  // ---------------- reference model: one slot describing what EX holds ----------------
  typedef struct {
    logic        v, known, alusrc, ill;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  ctl;
    logic [2:0]  gin;
    int          cnt;
  } ex_t;

  ex_t m;
  bit  m_stalled;

  function automatic logic [3:0] ref_dec(logic [1:0] op, logic [5:0] f);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b0001;
      default: case (f)
        6'b100000: return 4'b0010;
        6'b100010: return 4'b0110;
        6'b100100: return 4'b0000;
        6'b100101: return 4'b0001;
        6'b101010: return 4'b0111;
        6'b000011: return 4'b0011;
        default:   return 4'b1010;
      endcase
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(logic [4:0] num, logic [31:0] data);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == num) return exmem_result;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == num) return memwb_result;
    return data;
  endfunction

  function automatic logic ref_hazard();
    return m.v && m.ctl[3] && m.dest != 0 && id_valid &&
           (m.dest == id_rs_num || m.dest == id_rt_num);
  endfunction

  task automatic model_check();
    chk("m.stall", stall, ref_hazard() && !flush);
    chk("m.ex_valid", ex_valid, m.v);
    chk("m.ex_ctl", ex_ctl, m.ctl);
    chk("m.illegal", illegal, m.ill);
    chk("m.stall_count", stall_count, m.cnt);
    if (m.known) begin
      chk("m.gin", gin, m.gin);
      chk("m.alu_a", alu_a, ref_fwd(m.rs, m.rsd));
      chk("m.alu_b", alu_b, m.alusrc ? m.imm : ref_fwd(m.rt, m.rtd));
      chk("m.store_data", store_data, ref_fwd(m.rt, m.rtd));
      chk("m.ex_dest", ex_dest, m.dest);
    end
  endtask

  task automatic model_step();
    logic       haz;
    logic [3:0] d;
    haz = ref_hazard();
    m_stalled = haz && !flush;
    if (reset) begin
      m = '{v: 0, known: 1, alusrc: 0, ill: 0, rs: 0, rt: 0, dest: 0, rsd: 0, rtd: 0,
            imm: 0, ctl: 0, gin: 3'b010, cnt: 0};
    end else begin
      if (m_stalled && m.cnt < 65535) m.cnt++;
      if (flush || haz) begin
        m.v = 0; m.ctl = 0; m.ill = 0; m.known = 0;
      end else begin
        d = ref_dec(id_aluop, id_funct);
        m.v = id_valid; m.known = 1;
        m.rs = id_rs_num; m.rt = id_rt_num; m.rsd = id_rs_data; m.rtd = id_rt_data;
        m.imm = id_imm; m.alusrc = id_ctl[4];
        m.dest = id_ctl[5] ? id_rd_num : id_rt_num;
        m.ctl = id_valid ? id_ctl[3:0] : 4'b0000;
        m.gin = d[2:0];
        m.ill = d[3] && id_valid;
      end
    end
  endtask

  task automatic cycle(input vin_t v, input vexp_t e, input int row, input bit use_model);
    drive(v);
    @(negedge clk);
    if (e.chk > 0) begin
      chk($sformatf("row%0d stall", row), stall, e.stall);
      chk($sformatf("row%0d ex_valid", row), ex_valid, e.exv);
      chk($sformatf("row%0d ex_ctl", row), ex_ctl, e.ctl);
      chk($sformatf("row%0d illegal", row), illegal, e.ill);
      chk($sformatf("row%0d stall_count", row), stall_count, e.cnt);
      if (e.chk > 1) begin
        chk($sformatf("row%0d gin", row), gin, e.gin);
        chk($sformatf("row%0d alu_a", row), alu_a, e.a);
        chk($sformatf("row%0d alu_b", row), alu_b, e.b);
        chk($sformatf("row%0d store_data", row), store_data, e.sd);
        chk($sformatf("row%0d ex_dest", row), ex_dest, e.dest);
      end
    end
    if (use_model) model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] C_R   = 6'b100001;
  localparam logic [5:0] C_LW  = 6'b011011;
  localparam logic [5:0] C_ORI = 6'b010001;

  initial begin
    vin_t  v, cur;
    vexp_t none;
    logic [5:0] functs [6];
    none = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
    functs[3] = 6'b100101; functs[4] = 6'b101010; functs[5] = 6'b000011;

    // 0-1: reset held two cycles
    add(I(1,0,0,0,0,0,0,0,0,0,0), none);
    add(I(1,0,0,0,0,0,0,0,0,0,0), E(2,0,0,3'b010,0,0,0,0,0,0,0));
    // 2-3: R-type sub 9 - 4
    add(I(0,1,1,2,3,9,4,0,2'b10,6'b100010,C_R), E(2,0,0,3'b010,0,0,0,0,0,0,0));
    add(I(0,0,0,0,0,0,0,0,0,0,0), E(2,0,1,3'b110,9,4,4,3,4'b0001,0,0));
    // 4-6: forwarding priority and register-0 exclusion
    add(I(0,1,5,6,7,32'h55,32'h66,0,2'b10,6'b100000,C_R), E(2,0,0,3'b010,0,0,0,0,0,0,0));
    v = I(0,1,0,5,8,32'h77,32'h88,0,2'b10,6'b100100,C_R);
    v.xw = 1; v.xrd = 5; v.xres = 32'h11; v.ww = 1; v.wrd = 5; v.wres = 32'h22;
    add(v, E(2,0,1,3'b010,32'h11,32'h66,32'h66,7,4'b0001,0,0));
    v = I(0,0,0,0,0,0,0,0,0,0,0);
    v.xw = 1; v.xrd = 0; v.xres = 32'h11; v.ww = 1; v.wrd = 5; v.wres = 32'h22;
    add(v, E(2,0,1,3'b000,32'h77,32'h22,32'h22,8,4'b0001,0,0));
    // 7-10: lw $8 followed by a use of $8
    add(I(0,1,1,8,0,32'h100,0,4,2'b00,0,C_LW), E(2,0,0,3'b010,0,0,0,0,0,0,0));
    add(I(0,1,8,2,9,32'hAA,3,0,2'b10,6'b100000,C_R), E(2,1,1,3'b010,32'h100,4,0,8,4'b1011,0,0));
    add(I(0,1,8,2,9,32'hAA,3,0,2'b10,6'b100000,C_R), E(1,0,0,0,0,0,0,0,0,0,1));
    v = I(0,0,0,0,0,0,0,0,0,0,0);
    v.ww = 1; v.wrd = 8; v.wres = 32'h500;
    add(v, E(2,0,1,3'b010,32'h500,3,3,9,4'b0001,0,1));
    // 11-13: flush coincident with load-use hazard
    add(I(0,1,1,10,0,32'h200,0,8,2'b00,0,C_LW), E(2,0,0,3'b010,0,0,0,0,0,0,1));
    v = I(0,1,10,10,11,0,0,0,2'b10,6'b100101,C_R);
    v.flush = 1;
    add(v, E(2,0,1,3'b010,32'h200,8,0,10,4'b1011,0,1));
    add(I(0,0,0,0,0,0,0,0,0,0,0), E(1,0,0,0,0,0,0,0,0,0,1));
    // 14-19: decode of illegal funct, sra, ori, beq, illegal-with-invalid
    add(I(0,1,2,3,4,1,2,0,2'b10,6'b111111,C_R), E(2,0,0,3'b010,0,0,0,0,0,0,1));
    add(I(0,1,2,3,5,32'h80000000,4,0,2'b10,6'b000011,C_R), E(2,0,1,3'b010,1,2,2,4,4'b0001,1,1));
    add(I(0,1,6,7,0,32'hF0,0,32'h0F,2'b11,0,C_ORI), E(2,0,1,3'b011,32'h80000000,4,4,5,4'b0001,0,1));
    add(I(0,1,1,2,0,5,5,0,2'b01,0,6'b000000), E(2,0,1,3'b001,32'hF0,32'h0F,0,7,4'b0001,0,1));
    add(I(0,0,0,0,0,0,0,0,2'b10,6'b111111,C_R), E(2,0,1,3'b110,5,5,5,2,4'b0000,0,1));
    add(I(0,1,1,0,0,0,0,0,2'b00,0,C_LW), E(2,0,0,3'b010,0,0,0,0,4'b0000,0,1));
    // 20: load into $0 never stalls its consumer
    add(I(0,1,0,0,1,0,0,0,2'b10,6'b100000,C_R), E(2,0,1,3'b010,0,0,0,0,4'b1011,0,1));
    // 21-24: reset arriving while a stall is pending discards the bubble
    add(I(0,1,1,8,0,32'h100,0,4,2'b00,0,C_LW), E(2,0,1,3'b010,0,0,0,1,4'b0001,0,1));
    add(I(1,1,8,2,9,32'hAA,3,0,2'b10,6'b100000,C_R), E(2,1,1,3'b010,32'h100,4,0,8,4'b1011,0,1));
    add(I(0,1,8,2,9,32'hAA,3,0,2'b10,6'b100000,C_R), E(2,0,0,3'b010,0,0,0,0,0,0,0));
    add(I(0,0,0,0,0,0,0,0,0,0,0), E(2,0,1,3'b010,32'hAA,3,3,9,4'b0001,0,0));

    foreach (tbl[k]) cycle(tbl[k].i, tbl[k].e, k, 1'b0);

    // random traffic; a stalled ID instruction is re-presented unchanged
    cur = I(0,0,0,0,0,0,0,0,0,0,0);
    for (int n = 0; n < 400; n++) begin
      if (!m_stalled) begin
        cur.idv   = ($urandom_range(0, 7) != 0);
        cur.rs    = 5'($urandom_range(0, 3));
        cur.rt    = 5'($urandom_range(0, 3));
        cur.rd    = 5'($urandom_range(0, 3));
        cur.rsd   = $urandom;
        cur.rtd   = $urandom;
        cur.imm   = $urandom;
        cur.aluop = 2'($urandom_range(0, 3));
        cur.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                : functs[$urandom_range(0, 5)];
        cur.ctl   = 6'($urandom_range(0, 63));
      end
      cur.rst   = ($urandom_range(0, 49) == 0);
      cur.flush = ($urandom_range(0, 9) == 0);
      cur.xw    = 1'($urandom_range(0, 1));
      cur.xrd   = 5'($urandom_range(0, 3));
      cur.xres  = $urandom;
      cur.ww    = 1'($urandom_range(0, 1));
      cur.wrd   = 5'($urandom_range(0, 3));
      cur.wres  = $urandom;
      cycle(cur, none, 1000 + n, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
